// File: rtl/ctrlport_timeout_bridge_if.sv
// Control-port request/response bundle shared by the upstream and downstream
// sides of the timeout bridge.
interface ctrlport_timeout_bridge_if;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_byte_en;
  logic        resp_ack;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;

  modport master (
    output req_wr, req_rd, req_addr, req_data, req_byte_en,
    input  resp_ack, resp_status, resp_data
  );

  modport slave (
    input  req_wr, req_rd, req_addr, req_data, req_byte_en,
    output resp_ack, resp_status, resp_data
  );
endinterface

// File: rtl/ctrlport_timeout_bridge.sv
// Single-outstanding ctrlport stage: forwards one request at a time downstream
// and answers upstream with an error ack if the slave stays silent too long.
module ctrlport_timeout_bridge #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                      ctrlport_clk,
  input  logic                      ctrlport_rst_n,
  ctrlport_timeout_bridge_if.slave  s,
  ctrlport_timeout_bridge_if.master m,
  output logic [CNT_W-1:0]          timeout_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      stray_ack
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_CMDERR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             req_wr_q, req_wr_d;
  logic             req_rd_q, req_rd_d;
  logic [19:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       byte_en_q, byte_en_d;
  logic             ack_q, ack_d;
  logic [1:0]       status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             stray_q, stray_d;
  logic [CNT_W-1:0] tcnt_q, dcnt_q;
  logic             tcnt_inc, dcnt_inc;

  always_ff @(posedge ctrlport_clk) begin
    if (!ctrlport_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // REQ is the cycle the downstream strobe is high; the timer only runs in WAIT
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    req_wr_d  = 1'b0;
    req_rd_d  = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    byte_en_d = byte_en_q;
    ack_d     = 1'b0;
    status_d  = ST_OKAY;
    rdata_d   = '0;
    stray_d   = 1'b0;
    tcnt_inc  = 1'b0;
    dcnt_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        stray_d = m.resp_ack;
        if (s.req_wr ^ s.req_rd) begin
          req_wr_d  = s.req_wr;
          req_rd_d  = s.req_rd;
          addr_d    = s.req_addr;
          wdata_d   = s.req_data;
          byte_en_d = s.req_byte_en;
          state_d   = REQ;
        end else if (s.req_wr && s.req_rd) begin
          ack_d    = 1'b1;
          status_d = ST_CMDERR;
        end
      end

      REQ, WAIT: begin
        dcnt_inc = s.req_wr | s.req_rd;
        if (m.resp_ack) begin
          ack_d    = 1'b1;
          status_d = m.resp_status;
          rdata_d  = m.resp_data;
          timer_d  = '0;
          state_d  = IDLE;
        end else if (state_q == REQ) begin
          state_d = WAIT;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          ack_d    = 1'b1;
          status_d = ST_CMDERR;
          tcnt_inc = 1'b1;
          timer_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ctrlport_clk) begin
    if (!ctrlport_rst_n) begin
      timer_q   <= '0;
      req_wr_q  <= 1'b0;
      req_rd_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_en_q <= '0;
      ack_q     <= 1'b0;
      status_q  <= '0;
      rdata_q   <= '0;
      stray_q   <= 1'b0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      timer_q   <= timer_d;
      req_wr_q  <= req_wr_d;
      req_rd_q  <= req_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      byte_en_q <= byte_en_d;
      ack_q     <= ack_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      stray_q   <= stray_d;
      // Event counters stick at all-ones rather than wrapping
      if (tcnt_inc && (tcnt_q != '1)) begin
        tcnt_q <= tcnt_q + CNT_W'(1);
      end
      if (dcnt_inc && (dcnt_q != '1)) begin
        dcnt_q <= dcnt_q + CNT_W'(1);
      end
    end
  end

  assign m.req_wr      = req_wr_q;
  assign m.req_rd      = req_rd_q;
  assign m.req_addr    = addr_q;
  assign m.req_data    = wdata_q;
  assign m.req_byte_en = byte_en_q;
  assign s.resp_ack    = ack_q;
  assign s.resp_status = status_q;
  assign s.resp_data   = rdata_q;
  assign timeout_count = tcnt_q;
  assign drop_count    = dcnt_q;
  assign stray_ack     = stray_q;

endmodule

// File: tb/tb_ctrlport_timeout_bridge.sv
// Directed bench for ctrlport_timeout_bridge: a per-cycle vector table followed
// by hand-written timeout, boundary-ack, reset-abandon and saturation sequences.
module tb_ctrlport_timeout_bridge;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 3;
  localparam int NV      = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] drop_count;
  logic             stray_ack;

  int compared = 0;
  int mismatched = 0;

  ctrlport_timeout_bridge_if up ();
  ctrlport_timeout_bridge_if dn ();

  ctrlport_timeout_bridge #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .ctrlport_clk  (clk),
    .ctrlport_rst_n(rst_n),
    .s             (up),
    .m             (dn),
    .timeout_count (timeout_count),
    .drop_count    (drop_count),
    .stray_ack     (stray_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        mack;
    logic [1:0]  mstat;
    logic [31:0] mdata;
    logic [1:0]  e_mreq;
    logic [19:0] e_maddr;
    logic [31:0] e_mdata;
    logic [3:0]  e_mbe;
    logic        e_sack;
    logic [1:0]  e_sstat;
    logic [31:0] e_sdata;
    logic        e_stray;
    logic [2:0]  e_drop;
  } vec_t;

  vec_t vecs [NV];
  int   n;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    up.req_wr      = 1'b0;
    up.req_rd      = 1'b0;
    up.req_addr    = '0;
    up.req_data    = '0;
    up.req_byte_en = '0;
    dn.resp_ack    = 1'b0;
    dn.resp_status = '0;
    dn.resp_data   = '0;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    up.req_wr      = v.wr;
    up.req_rd      = v.rd;
    up.req_addr    = v.addr;
    up.req_data    = v.data;
    up.req_byte_en = v.be;
    dn.resp_ack    = v.mack;
    dn.resp_status = v.mstat;
    dn.resp_data   = v.mdata;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected in the following cycle
    vecs[0]  = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h0,  32'h0,        4'h0, 1'b0, 2'b00, 32'h0,        1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 20'h00010, 32'h0,        4'hF, 1'b0, 2'b00, 32'h0,
                 2'b01, 20'h10, 32'h0,        4'hF, 1'b0, 2'b00, 32'h0,        1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h10, 32'h0,        4'hF, 1'b0, 2'b00, 32'h0,        1'b0, 3'd0};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 2'b00, 32'hDEADBEEF,
                 2'b00, 20'h10, 32'h0,        4'hF, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 20'h00004, 32'h12345678, 4'h3, 1'b0, 2'b00, 32'h0,
                 2'b10, 20'h4,  32'h12345678, 4'h3, 1'b0, 2'b00, 32'h0,        1'b0, 3'd0};
    vecs[7]  = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 2'b11, 32'hCAFEF00D,
                 2'b00, 20'h4,  32'h12345678, 4'h3, 1'b1, 2'b11, 32'hCAFEF00D, 1'b0, 3'd0};
    vecs[8]  = '{1'b1, 1'b1, 20'h00099, 32'h1,        4'hF, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h4,  32'h12345678, 4'h3, 1'b1, 2'b01, 32'h0,        1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 2'b00, 32'h55,
                 2'b00, 20'h4,  32'h12345678, 4'h3, 1'b0, 2'b00, 32'h0,        1'b1, 3'd0};
    vecs[10] = '{1'b0, 1'b1, 20'h00020, 32'hAAAA,     4'h1, 1'b0, 2'b00, 32'h0,
                 2'b01, 20'h20, 32'hAAAA,     4'h1, 1'b0, 2'b00, 32'h0,        1'b0, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 20'h00030, 32'h1,        4'hF, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h20, 32'hAAAA,     4'h1, 1'b0, 2'b00, 32'h0,        1'b0, 3'd1};
    vecs[12] = '{1'b0, 1'b1, 20'h00040, 32'h2,        4'hF, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h20, 32'hAAAA,     4'h1, 1'b0, 2'b00, 32'h0,        1'b0, 3'd2};
    vecs[13] = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 2'b10, 32'h0BADF00D,
                 2'b00, 20'h20, 32'hAAAA,     4'h1, 1'b1, 2'b10, 32'h0BADF00D, 1'b0, 3'd2};
    vecs[14] = '{1'b0, 1'b0, 20'h0,     32'h0,        4'h0, 1'b0, 2'b00, 32'h0,
                 2'b00, 20'h20, 32'hAAAA,     4'h1, 1'b0, 2'b00, 32'h0,        1'b0, 3'd2};

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_output("rst_mreq",   {dn.req_wr, dn.req_rd}, 2'b00);
    check_output("rst_maddr",  dn.req_addr, 20'h0);
    check_output("rst_mdata",  dn.req_data, 32'h0);
    check_output("rst_mbe",    dn.req_byte_en, 4'h0);
    check_output("rst_sack",   up.resp_ack, 1'b0);
    check_output("rst_sdata",  up.resp_data, 32'h0);
    check_output("rst_counts", {timeout_count, drop_count, stray_ack}, 7'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("v%0d_mreq", i),  {dn.req_wr, dn.req_rd}, vecs[i].e_mreq);
      check_output($sformatf("v%0d_maddr", i), dn.req_addr, vecs[i].e_maddr);
      check_output($sformatf("v%0d_mdata", i), dn.req_data, vecs[i].e_mdata);
      check_output($sformatf("v%0d_mbe", i),   dn.req_byte_en, vecs[i].e_mbe);
      check_output($sformatf("v%0d_sack", i),  up.resp_ack, vecs[i].e_sack);
      check_output($sformatf("v%0d_sstat", i), up.resp_status, vecs[i].e_sstat);
      check_output($sformatf("v%0d_sdata", i), up.resp_data, vecs[i].e_sdata);
      check_output($sformatf("v%0d_stray", i), stray_ack, vecs[i].e_stray);
      check_output($sformatf("v%0d_drop", i),  drop_count, vecs[i].e_drop);
      check_output($sformatf("v%0d_tout", i),  timeout_count, 3'd0);
    end

    // Silent slave: error ack lands 17 cycles after the downstream strobe
    do_reset();
    up.req_wr = 1'b1;
    up.req_addr = 20'h00004;
    up.req_data = 32'h11;
    up.req_byte_en = 4'hF;
    step();
    idle_inputs();
    check_output("to_mreq", {dn.req_wr, dn.req_rd}, 2'b10);
    n = 0;
    while ((up.resp_ack !== 1'b1) && (n < 100)) begin
      step();
      n++;
    end
    check_output("to_latency", n, 17);
    check_output("to_sstat",   up.resp_status, 2'b01);
    check_output("to_sdata",   up.resp_data, 32'h0);
    check_output("to_count",   timeout_count, 3'd1);
    step();
    check_output("to_pulse",   up.resp_ack, 1'b0);

    // Ack on the final timer value wins over the timeout
    do_reset();
    up.req_wr = 1'b1;
    up.req_addr = 20'h00008;
    step();
    idle_inputs();
    check_output("edge_mreq", {dn.req_wr, dn.req_rd}, 2'b10);
    repeat (16) step();
    check_output("edge_no_early", up.resp_ack, 1'b0);
    dn.resp_ack = 1'b1;
    dn.resp_status = 2'b11;
    dn.resp_data = 32'h600DCAFE;
    step();
    idle_inputs();
    check_output("edge_sack",  up.resp_ack, 1'b1);
    check_output("edge_sstat", up.resp_status, 2'b11);
    check_output("edge_sdata", up.resp_data, 32'h600DCAFE);
    check_output("edge_tout",  timeout_count, 3'd0);

    // Reset while waiting abandons the transaction; the late ack is stray
    do_reset();
    up.req_rd = 1'b1;
    up.req_addr = 20'h00050;
    step();
    idle_inputs();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_output("rw_maddr", dn.req_addr, 20'h0);
    dn.resp_ack = 1'b1;
    dn.resp_data = 32'h77;
    step();
    idle_inputs();
    check_output("rw_stray", stray_ack, 1'b1);
    check_output("rw_sack",  up.resp_ack, 1'b0);
    step();
    check_output("rw_stray_once", stray_ack, 1'b0);
    check_output("rw_counts", {timeout_count, drop_count}, 6'h0);

    // Nine dropped requests must saturate a 3-bit counter at 7
    do_reset();
    up.req_rd = 1'b1;
    up.req_addr = 20'h00060;
    step();
    up.req_rd = 1'b0;
    up.req_wr = 1'b1;
    repeat (9) step();
    idle_inputs();
    check_output("sat_drop", drop_count, 3'd7);
    dn.resp_ack = 1'b1;
    dn.resp_data = 32'h1234;
    step();
    idle_inputs();
    check_output("sat_sack",  up.resp_ack, 1'b1);
    check_output("sat_sdata", up.resp_data, 32'h1234);
    check_output("sat_hold",  drop_count, 3'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
